// File: rtl/servo_pulse_decoder_pkg.sv
// Shared definitions for the servo pulse encoder/decoder pair.
package servo_pulse_decoder_pkg;

    // Default timing constants (50 MHz clock), shared with the drive block.
    localparam int unsigned CNT_W_DEF      = 21;
    localparam int unsigned MIN_HIGH_DEF   = 50000;
    localparam int unsigned MAX_HIGH_DEF   = 100000;
    localparam int unsigned STOP_LO_DEF    = 73000;
    localparam int unsigned STOP_HI_DEF    = 77000;
    localparam int unsigned MAX_PERIOD_DEF = 1250000;

    // Direction code carried on dirCode; 2'b11 is never driven.
    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_LO   = 2'b01,
        DIR_HI   = 2'b10
    } dir_e;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_e;

endpackage

// File: rtl/servo_pulse_decoder_sync_edge.sv
// Two-flop synchroniser with single-cycle rise/fall strobes on the synchronised level.
module servo_pulse_decoder_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic [1:0] fill_q,  fill_d;
    logic       armed;

    // Shift the pin through the synchroniser; count until the chain holds real samples.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end

    // Synchroniser, edge history and fill counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
        end
    end

    // Edges only count once both compared samples came from the pin, so a level
    // already high when reset is released is not reported as a rise.
    assign armed  = (fill_q == 2'd3);
    assign rise_c = armed &  sync2_q & ~prev_q;
    assign fall_c = armed & ~sync2_q &  prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM high time, classifies direction, flags bad pulses and train loss.
module servo_pulse_decoder
    import servo_pulse_decoder_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned MIN_HIGH   = MIN_HIGH_DEF,
    parameter int unsigned MAX_HIGH   = MAX_HIGH_DEF,
    parameter int unsigned STOP_LO    = STOP_LO_DEF,
    parameter int unsigned STOP_HI    = STOP_HI_DEF,
    parameter int unsigned MAX_PERIOD = MAX_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulseIn,
    output logic [CNT_W-1:0] pulseWidth,
    output logic [1:0]       dirCode,
    output logic             sampleValid,
    output logic             pulseErr,
    output logic             signalLost
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] STOP_LO_C = CNT_W'(STOP_LO);
    localparam logic [CNT_W-1:0] STOP_HI_C = CNT_W'(STOP_HI);
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(MAX_PERIOD);

    logic rise_c, fall_c;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
    dir_e             dir_q, dir_d;
    logic             sample_valid_q, sample_valid_d;
    logic             pulse_err_q, pulse_err_d;
    logic             signal_lost_q, signal_lost_d;
    logic [CNT_W-1:0] hi_inc_c, per_inc_c;

    servo_pulse_decoder_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .din    (pulseIn),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Saturating increments so long gaps never wrap back into the legal range.
    assign hi_inc_c  = (hi_cnt_q  == CNT_MAX) ? hi_cnt_q  : hi_cnt_q  + CNT_ONE;
    assign per_inc_c = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;

    // Next-state, counter and classifier logic.
    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        per_cnt_d      = per_cnt_q;
        pulse_width_d  = pulse_width_q;
        dir_d          = dir_q;
        sample_valid_d = 1'b0;
        pulse_err_d    = 1'b0;
        signal_lost_d  = signal_lost_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_d       = ST_HIGH;
                    hi_cnt_d      = CNT_ONE;
                    per_cnt_d     = CNT_ONE;
                    signal_lost_d = 1'b0;
                end
            end
            ST_HIGH: begin
                hi_cnt_d  = hi_inc_c;
                per_cnt_d = per_inc_c;
                if (fall_c) begin
                    state_d  = ST_LOW;
                    hi_cnt_d = hi_cnt_q;
                    if ((hi_cnt_q >= MIN_C) && (hi_cnt_q <= MAX_C)) begin
                        sample_valid_d = 1'b1;
                        pulse_width_d  = hi_cnt_q;
                        if ((hi_cnt_q >= STOP_LO_C) && (hi_cnt_q <= STOP_HI_C)) begin
                            dir_d = DIR_STOP;
                        end else if (hi_cnt_q < STOP_LO_C) begin
                            dir_d = DIR_LO;
                        end else begin
                            dir_d = DIR_HI;
                        end
                    end else begin
                        pulse_err_d = 1'b1;
                    end
                end else if (hi_cnt_q >= PERIOD_C) begin
                    state_d       = ST_IDLE;
                    signal_lost_d = 1'b1;
                    dir_d         = DIR_STOP;
                end
            end
            ST_LOW: begin
                per_cnt_d = per_inc_c;
                if (rise_c) begin
                    state_d       = ST_HIGH;
                    hi_cnt_d      = CNT_ONE;
                    per_cnt_d     = CNT_ONE;
                    signal_lost_d = 1'b0;
                end else if (per_cnt_q >= PERIOD_C) begin
                    state_d       = ST_IDLE;
                    signal_lost_d = 1'b1;
                    dir_d         = DIR_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            hi_cnt_q       <= '0;
            per_cnt_q      <= '0;
            pulse_width_q  <= '0;
            dir_q          <= DIR_STOP;
            sample_valid_q <= 1'b0;
            pulse_err_q    <= 1'b0;
            signal_lost_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            per_cnt_q      <= per_cnt_d;
            pulse_width_q  <= pulse_width_d;
            dir_q          <= dir_d;
            sample_valid_q <= sample_valid_d;
            pulse_err_q    <= pulse_err_d;
            signal_lost_q  <= signal_lost_d;
        end
    end

    assign pulseWidth  = pulse_width_q;
    assign dirCode     = 2'(dir_q);
    assign sampleValid = sample_valid_q;
    assign pulseErr    = pulse_err_q;
    assign signalLost  = signal_lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with reduced timing constants.
module tb_servo_pulse_decoder;

    localparam int unsigned CNT_W      = 12;
    localparam int unsigned MIN_HIGH   = 100;
    localparam int unsigned MAX_HIGH   = 200;
    localparam int unsigned STOP_LO    = 145;
    localparam int unsigned STOP_HI    = 155;
    localparam int unsigned MAX_PERIOD = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulseIn;
    logic [CNT_W-1:0] pulseWidth;
    logic [1:0]       dirCode;
    logic             sampleValid;
    logic             pulseErr;
    logic             signalLost;

    typedef struct {
        bit               is_err;
        logic [CNT_W-1:0] width;
        logic [1:0]       dir;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] mdl_width;
    logic [1:0]       mdl_dir;

    servo_pulse_decoder #(
        .CNT_W      (CNT_W),
        .MIN_HIGH   (MIN_HIGH),
        .MAX_HIGH   (MAX_HIGH),
        .STOP_LO    (STOP_LO),
        .STOP_HI    (STOP_HI),
        .MAX_PERIOD (MAX_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulseIn     (pulseIn),
        .pulseWidth  (pulseWidth),
        .dirCode     (dirCode),
        .sampleValid (sampleValid),
        .pulseErr    (pulseErr),
        .signalLost  (signalLost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a pulse of h clocks is legal iff it lies in [MIN_HIGH, MAX_HIGH];
    // legal pulses update width and direction, illegal ones leave both unchanged.
    task automatic predict(input int h);
        exp_t e;
        if (h >= int'(MIN_HIGH) && h <= int'(MAX_HIGH)) begin
            mdl_width = CNT_W'(h);
            if (h >= int'(STOP_LO) && h <= int'(STOP_HI)) mdl_dir = 2'd0;
            else if (h < int'(STOP_LO))                   mdl_dir = 2'd1;
            else                                          mdl_dir = 2'd2;
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.width = mdl_width;
        e.dir   = mdl_dir;
        exp_q.push_back(e);
    endtask

    // Drive one pulse: pin high for h clock edges, then low until period p elapses.
    task automatic issue_pulse(input int h, input int p);
        predict(h);
        pulseIn = 1'b1;
        repeat (h) @(posedge clk);
        #1 pulseIn = 1'b0;
        repeat (p - h) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_width"}, int'(pulseWidth), 0);
        check({tag, "_dir"},   int'(dirCode), 0);
        check({tag, "_lost"},  int'(signalLost), 1);
        check({tag, "_valid"}, int'(sampleValid), 0);
        check({tag, "_err"},   int'(pulseErr), 0);
    endtask

    // Monitor: every strobe must match the oldest predicted pulse outcome.
    always @(negedge clk) begin
        if (!rst && (sampleValid || pulseErr)) begin
            check("strobe_exclusive", int'(sampleValid & pulseErr), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b width=%0d, none expected (t=%0t)",
                         sampleValid, pulseErr, pulseWidth, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_is_err",  int'(pulseErr), int'(mon_e.is_err));
                check("strobe_width",   int'(pulseWidth), int'(mon_e.width));
                check("strobe_dir",     int'(dirCode), int'(mon_e.dir));
                check("strobe_lost",    int'(signalLost), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int p;
        mdl_width = '0;
        mdl_dir   = 2'd0;
        rst       = 1'b1;
        pulseIn   = 1'b0;
        repeat (5) @(posedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Quiet line: stays lost, no strobes.
        repeat (2500) @(posedge clk);
        @(negedge clk);
        check("quiet_lost", int'(signalLost), 1);
        check("quiet_dir",  int'(dirCode), 0);
        @(posedge clk);
        #1;

        // Centre pulses, then legal boundaries and stop-band edges, then illegal lengths.
        repeat (3) issue_pulse(150, 1000);
        check("lost_cleared", int'(signalLost), 0);
        issue_pulse(100, 1000);
        issue_pulse(200, 1000);
        issue_pulse(99, 1000);
        issue_pulse(201, 1000);
        issue_pulse(144, 1000);
        issue_pulse(145, 1000);
        issue_pulse(155, 1000);
        issue_pulse(156, 1000);

        // Loss of train after a low-direction pulse: dirCode forced to stop, width holds.
        predict(120);
        pulseIn = 1'b1;
        repeat (120) @(posedge clk);
        #1 pulseIn = 1'b0;
        repeat (1830) @(posedge clk);
        @(negedge clk);
        check("pre_timeout_lost", int'(signalLost), 0);
        check("pre_timeout_dir",  int'(dirCode), 1);
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("timeout_lost",  int'(signalLost), 1);
        check("timeout_dir",   int'(dirCode), 0);
        check("timeout_width", int'(pulseWidth), int'(mdl_width));
        mdl_dir = 2'd0;
        issue_pulse(99, 1000);
        issue_pulse(150, 1000);
        check("relock_lost", int'(signalLost), 0);

        // Reset in the middle of a pulse: no strobe for the truncated pulse.
        @(posedge clk);
        #1 pulseIn = 1'b1;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        mdl_width = '0;
        mdl_dir   = 2'd0;
        repeat (97) @(posedge clk);
        #1 pulseIn = 1'b0;
        repeat (900) @(posedge clk);
        @(negedge clk);
        check("midreset_still_lost", int'(signalLost), 1);
        @(posedge clk);
        #1;
        issue_pulse(180, 1000);

        // Randomised pulses around and beyond the legal window.
        for (int i = 0; i < 25; i++) begin
            h = int'($urandom_range(205, 95));
            p = h + int'($urandom_range(900, 20));
            issue_pulse(h, p);
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
